// File: rtl/spi_peripheral_pkg.sv
// spi_params: shared SPI word width, synchronizer depth and peripheral state encoding.
package spi_params;
    localparam int SPI_DATA_WIDTH = 8;
    localparam int SYNC_STAGES = 2;
    typedef enum logic {IDLE, ACTIVE} spi_peri_state_t;
endpackage

// File: rtl/spi_peripheral_sync.sv
// spi_sync: multi-flop synchronizer with a history flop giving level, rise and fall.
module spi_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sync_rst_n,
    input  logic sys_clk_en,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [DEPTH-1:0] chain;
    logic             hist;
    always_ff @(posedge sys_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            chain <= {DEPTH{RST_VAL}};
            hist  <= RST_VAL;
        end else if (sys_clk_en) begin
            chain <= {chain[DEPTH-2:0], d};
            hist  <= chain[DEPTH-1];
        end
    end
    assign level = chain[DEPTH-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;
endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: oversampled SPI mode-0 target with a single-entry transmit buffer.
module spi_peripheral #(
    parameter int SPI_DATA_WIDTH = spi_params::SPI_DATA_WIDTH,
    parameter int SYNC_STAGES    = spi_params::SYNC_STAGES
) (
    input  logic                      sys_clk,
    input  logic                      sync_rst_n,
    input  logic                      sys_clk_en,
    input  logic                      p_clk,
    input  logic                      p_sel_n,
    input  logic                      copi,
    output logic                      cipo,
    input  logic [SPI_DATA_WIDTH-1:0] tx_data,
    input  logic                      tx_load,
    output logic                      tx_ready,
    output logic [SPI_DATA_WIDTH-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      tx_underrun,
    output logic                      frame_err,
    output logic                      busy
);
    import spi_params::*;
    localparam int W  = SPI_DATA_WIDTH;
    localparam int CW = $clog2(W);

    spi_peri_state_t state, state_n;
    logic            clk_lvl, clk_rise, clk_fall;
    logic            sel_lvl, sel_rise, sel_fall;
    logic            copi_s, copi_rise, copi_fall;
    logic            unused_sync;
    logic [CW-1:0]   bit_cnt;
    logic [W-1:0]    tx_shift, rx_shift, tx_buf;
    logic            tx_full, last, stop, start, load_tx, shift_tx, shift_rx;

    spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
        .sys_clk(sys_clk), .sync_rst_n(sync_rst_n), .sys_clk_en(sys_clk_en),
        .d(p_clk), .level(clk_lvl), .rise(clk_rise), .fall(clk_fall));
    spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sel_sync (
        .sys_clk(sys_clk), .sync_rst_n(sync_rst_n), .sys_clk_en(sys_clk_en),
        .d(p_sel_n), .level(sel_lvl), .rise(sel_rise), .fall(sel_fall));
    spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_copi_sync (
        .sys_clk(sys_clk), .sync_rst_n(sync_rst_n), .sys_clk_en(sys_clk_en),
        .d(copi), .level(copi_s), .rise(copi_rise), .fall(copi_fall));
    assign unused_sync = ^{clk_lvl, sel_lvl, copi_rise, copi_fall};

    always_ff @(posedge sys_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) state <= IDLE;
        else if (sys_clk_en) state <= state_n;
    end

    // Deselect wins over a coincident p_clk edge, so the edge is dropped.
    always_comb begin
        last     = bit_cnt == CW'(W - 1);
        start    = (state == IDLE) && sel_fall;
        stop     = (state == ACTIVE) && sel_rise;
        shift_rx = (state == ACTIVE) && !sel_rise && clk_rise;
        shift_tx = (state == ACTIVE) && !sel_rise && clk_fall && bit_cnt != '0;
        load_tx  = start || ((state == ACTIVE) && !sel_rise && clk_fall && bit_cnt == '0);
        state_n  = stop ? IDLE : start ? ACTIVE : state;
    end

    always_ff @(posedge sys_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else if (sys_clk_en) begin
            rx_valid    <= shift_rx && last;
            tx_underrun <= load_tx && !tx_full;
            frame_err   <= stop && bit_cnt != '0;
            if (load_tx) tx_shift <= tx_full ? tx_buf : '0;
            else if (shift_tx) tx_shift <= {tx_shift[W-2:0], 1'b0};
            if (shift_rx) rx_shift <= {rx_shift[W-2:0], copi_s};
            if (shift_rx && last) rx_data <= {rx_shift[W-2:0], copi_s};
            if (start || stop || (shift_rx && last)) bit_cnt <= '0;
            else if (shift_rx) bit_cnt <= bit_cnt + CW'(1);
            // Registered tx_full decides consumption; a load into an empty buffer serves the next word.
            if (tx_load && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end else if (load_tx) tx_full <= 1'b0;
        end
    end

    assign cipo     = (state == ACTIVE) & tx_shift[W-1];
    assign busy     = state == ACTIVE;
    assign tx_ready = ~tx_full;
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: scoreboard bench driving a 16-cycle SPI mode-0 controller model.
module tb_spi_peripheral;
    localparam int W = 8;

    logic         sys_clk = 1'b0, sync_rst_n = 1'b0, sys_clk_en = 1'b1;
    logic         p_clk = 1'b0, p_sel_n = 1'b1, copi = 1'b0, tx_load = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         cipo, tx_ready, rx_valid, tx_underrun, frame_err, busy;
    logic [W-1:0] rx_data, miso;
    int           n_tests = 0, n_fail = 0, n_rx = 0, n_unr = 0, n_ferr = 0;
    logic [W-1:0] exp_rx[$];

    spi_peripheral dut (
        .sys_clk(sys_clk), .sync_rst_n(sync_rst_n), .sys_clk_en(sys_clk_en),
        .p_clk(p_clk), .p_sel_n(p_sel_n), .copi(copi), .cipo(cipo),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .frame_err(frame_err), .busy(busy));

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (sync_rst_n) begin
            if (rx_valid) begin
                n_rx++;
                check("rx_expected", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (tx_underrun) n_unr++;
            if (frame_err) n_ferr++;
        end
    end

    task automatic clear();
        n_rx = 0; n_unr = 0; n_ferr = 0;
    endtask

    task automatic load(input logic [W-1:0] d);
        @(negedge sys_clk); tx_data = d; tx_load = 1'b1;
        @(negedge sys_clk); tx_load = 1'b0;
    endtask

    task automatic select();
        @(negedge sys_clk); p_sel_n = 1'b0;
        repeat (8) @(negedge sys_clk);
    endtask

    // One word of controller traffic; optionally ends the frame with the final p_clk fall.
    task automatic word(input logic [W-1:0] mosi, input int nbits, input bit fin,
                        input bit freeze, input logic [W-1:0] old_rx, output logic [W-1:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            copi = mosi[W-1-i];
            repeat (8) @(negedge sys_clk);
            p_clk = 1'b1;
            got = {got[W-2:0], cipo};
            if (freeze && i == nbits - 1) begin
                @(negedge sys_clk); sys_clk_en = 1'b0;
                repeat (3) @(negedge sys_clk);
                check("freeze_rx_data", rx_data, old_rx);
                check("freeze_rx_valid", n_rx, 0);
                sys_clk_en = 1'b1;
                repeat (7) @(negedge sys_clk);
            end else repeat (8) @(negedge sys_clk);
            p_clk = 1'b0;
            if (fin && i == nbits - 1) p_sel_n = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] m1, m2;
        p_clk = 1'($urandom); p_sel_n = 1'($urandom); copi = 1'($urandom);
        repeat (3) @(negedge sys_clk);
        check("rst_cipo", cipo, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        p_clk = 1'b0; p_sel_n = 1'b1; copi = 1'b0;
        repeat (3) @(negedge sys_clk);
        sync_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);

        clear();
        load(8'hA5);
        check("single_full", tx_ready, 0);
        exp_rx.push_back(8'h3C);
        select();
        check("single_consumed", tx_ready, 1);
        check("single_busy", busy, 1);
        word(8'h3C, 8, 1, 1, 8'h00, m1);
        check("single_miso", m1, 8'hA5);
        repeat (10) @(negedge sys_clk);
        check("single_nrx", n_rx, 1);
        check("single_unr", n_unr, 0);
        check("single_ferr", n_ferr, 0);
        check("single_idle", busy, 0);

        clear();
        load(8'h11);
        exp_rx.push_back(8'hF0);
        exp_rx.push_back(8'h0F);
        select();
        check("b2b_ready", tx_ready, 1);
        load(8'h22);
        check("b2b_full", tx_ready, 0);
        load(8'h66);
        word(8'hF0, 8, 0, 0, 8'h3C, m1);
        word(8'h0F, 8, 1, 0, 8'h3C, m2);
        check("b2b_miso0", m1, 8'h11);
        check("b2b_miso1", m2, 8'h22);
        repeat (10) @(negedge sys_clk);
        check("b2b_nrx", n_rx, 2);
        check("b2b_unr", n_unr, 0);
        check("b2b_ready_end", tx_ready, 1);

        clear();
        exp_rx.push_back(8'h5A);
        select();
        word(8'h5A, 8, 1, 0, 8'h0F, m1);
        check("unr_miso", m1, 8'h00);
        repeat (10) @(negedge sys_clk);
        check("unr_count", n_unr, 1);
        check("unr_nrx", n_rx, 1);
        check("unr_rx_data", rx_data, 8'h5A);

        clear();
        select();
        word(8'hFF, 5, 1, 0, 8'h5A, m1);
        repeat (10) @(negedge sys_clk);
        check("part_ferr", n_ferr, 1);
        check("part_nrx", n_rx, 0);
        check("part_rx_data", rx_data, 8'h5A);
        clear();
        exp_rx.push_back(8'h81);
        select();
        word(8'h81, 8, 1, 0, 8'h5A, m1);
        repeat (10) @(negedge sys_clk);
        check("part_next_nrx", n_rx, 1);
        check("part_next_ferr", n_ferr, 0);
        check("part_next_data", rx_data, 8'h81);

        select();
        word(8'hE7, 3, 0, 0, 8'h81, m1);
        clear();
        @(negedge sys_clk); sync_rst_n = 1'b0; p_sel_n = 1'b1; copi = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rx_data", rx_data, 0);
        sync_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        check("mid_rst_nrx", n_rx, 0);
        check("mid_rst_ferr", n_ferr, 0);
        check("mid_rst_unr", n_unr, 0);
        check("mid_rst_idle", busy, 0);
        clear();
        exp_rx.push_back(8'hC3);
        select();
        word(8'hC3, 8, 1, 0, 8'h00, m1);
        repeat (10) @(negedge sys_clk);
        check("post_rst_nrx", n_rx, 1);
        check("post_rst_data", rx_data, 8'hC3);
        check("post_rst_unr", n_unr, 1);
        check("post_rst_miso", m1, 8'h00);
        check("rx_queue_left", exp_rx.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
